// File: rtl/mem_pkg.sv
// Shared definitions for the memory read checker.
//   DEF_ADDR_W / DEF_DATA_W : default address and payload widths
//   state_t                 : checker FSM state encoding
//   parity_err()            : even-parity check used by the checker, the memory
//                             model and the benches. It returns 1 when the word
//                             (payload plus parity MSB) has odd parity.
package mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int PAR_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Callers zero-extend the word to PAR_MAX_W bits. Zero padding does not
  // change the XOR reduction.
  function automatic logic parity_err(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_rd_addr_gen.sv
// Address sequencing for a memory scan.
//   clk, rst_n   : clock and asynchronous active-low reset
//   load         : latch start_addr / num_words at the beginning of a scan
//   start_addr   : first address of the scan
//   num_words    : number of words to read
//   advance      : a read is issued this cycle
//   address      : current read address (holds its value when no read is issued)
//   last         : the read issued this cycle is the final one of the scan
//   addr_p1      : address of the read issued in the previous cycle
//   vld_p1       : a read was issued in the previous cycle, so data_out is valid now
module mem_rd_addr_gen
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       num_words,
  input  logic              advance,
  output logic [ADDR_W-1:0] address,
  output logic              last,
  output logic [ADDR_W-1:0] addr_p1,
  output logic              vld_p1
);

  logic [15:0] remaining;

  assign last = (remaining == 16'd1);

  // The counter does not step past the final read, so the address keeps the
  // last address that was read while the strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address   <= '0;
      remaining <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= advance;
      if (load) begin
        address   <= start_addr;
        remaining <= num_words;
      end else if (advance) begin
        remaining <= remaining - 16'd1;
        if (!last) address <= address + 1'b1;
      end
    end
  end

  // Stage p1: in-flight address, lined up with the returning data word
  always_ff @(posedge clk) begin
    addr_p1 <= address;
  end

endmodule

// File: rtl/mem_rd_checker.sv
// Scans a block of memory words and checks each word for even parity. The
// block also keeps a modulo-2^16 checksum of the payload bytes.
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : scan request pulse (ignored while busy)
//   start_addr     : first address to read
//   num_words      : number of words to read (0 gives an empty scan)
//   read, address  : memory read strobe and address
//   data_out       : memory data, valid the cycle after read (MSB = parity bit)
//   busy, done     : scan in progress / one-cycle end-of-scan pulse
//   err_count      : saturating count of parity failures
//   first_err_addr : address of the first failing word of the scan
//   err_flag       : at least one failure in this scan
//   checksum       : sum of the payload fields, modulo 2^16
module mem_rd_checker
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       num_words,
  output logic              read,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W:0]   data_out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag,
  output logic [15:0]       checksum
);

  state_t            state_q, state_d;
  logic              accept;
  logic              load;
  logic              last;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              perr_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] wrap_add16(input logic [15:0] acc,
                                             input logic [DATA_W-1:0] payload);
    return acc + 16'(payload);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (num_words != 16'd0) ? RUN : DONE;
        end
      end
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign read = (state_q == RUN);
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign load = accept && (num_words != 16'd0);

  mem_rd_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .start_addr (start_addr),
    .num_words  (num_words),
    .advance    (read),
    .address    (address),
    .last       (last),
    .addr_p1    (addr_p1),
    .vld_p1     (vld_p1)
  );

  // Stage p1: the returning word is checked against the address that was read
  assign perr_p1 = parity_err(PAR_MAX_W'(data_out));

  // An accepted start and a valid data word never occur in the same cycle.
  // Start is accepted only in IDLE, and vld_p1 is high only in RUN and DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
      checksum       <= '0;
    end else if (accept) begin
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
      checksum       <= '0;
    end else if (vld_p1) begin
      checksum <= wrap_add16(checksum, data_out[DATA_W-1:0]);
      if (perr_p1) begin
        err_count <= sat_inc16(err_count);
        if (!err_flag) begin
          err_flag       <= 1'b1;
          first_err_addr <= addr_p1;
        end
      end
    end
  end

endmodule
